// File: rtl/types_pkg.sv
// rtl/types_pkg.sv - shared ALU operation types and LFSR constants
// Purpose: op_type encoding for the 16-bit two-operand ALU port, the LFSR tap
//          mask and the "no failure seen" marker used by alu_op_driver.
// Ports:   none (package).
package types_pkg;

    typedef enum logic [1:0] {
        ADD = 2'd0,
        SUB = 2'd1,
        MUL = 2'd2,
        DIV = 2'd3
    } op_type;

    // Feedback taps s[15], s[13], s[12], s[10].
    localparam logic [15:0] LFSR_TAPS   = 16'hB400;
    localparam logic [15:0] NO_FAIL_IDX = 16'hFFFF;

    // One Fibonacci step: shift left, parity of the tapped bits enters at bit 0.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/alu_ref_model.sv
// rtl/alu_ref_model.sv - combinational expected-result function for the ALU port
// Purpose: computes the 32-bit result the ALU must return for (v1, v2, mode).
// Ports:
//   v1, v2    in  16  unsigned operands
//   mode      in  op_type operation select
//   expected  out 32  ADD/SUB wrap to 32 bits, MUL full product,
//                     DIV truncates, divide by zero gives all ones
module alu_ref_model
    import types_pkg::*;
(
    input  logic [15:0] v1,
    input  logic [15:0] v2,
    input  op_type      mode,
    output logic [31:0] expected
);

    logic [31:0] a_ext;
    logic [31:0] b_ext;

    assign a_ext = {16'd0, v1};
    assign b_ext = {16'd0, v2};

    always_comb begin
        expected = 32'd0;
        unique case (mode)
            ADD: expected = a_ext + b_ext;
            SUB: expected = a_ext - b_ext;
            MUL: expected = a_ext * b_ext;
            DIV: expected = (v2 == 16'd0) ? 32'hFFFF_FFFF : {16'd0, v1 / v2};
            default: expected = 32'd0;
        endcase
    end

endmodule

// File: rtl/alu_op_driver.sv
// rtl/alu_op_driver.sv - pseudo-random ALU stimulus generator and result checker
// Purpose: drives LFSR-generated operand pairs and a rotating mode into the ALU,
//          compares the ALU result LATENCY cycles later against alu_ref_model
//          and keeps pass/fail counters plus the index of the first mismatch.
// Build option: ALU_DRV_STOP_ON_FAIL_EN - when defined the first mismatch ends
//          the run; otherwise every one of NUM_OPS operations is executed.
// Parameters: NUM_OPS (1..65535), LATENCY (0..15), SEED (0 maps to 16'h0001).
// Ports:
//   clock           in  1   rising-edge clock
//   reset           in  1   synchronous, active-high
//   start           in  1   begins a run when idle or done
//   value1, value2  out 16  registered operands
//   mode            out op_type registered operation select
//   result          in  32  ALU result
//   busy            out 1   run in progress
//   done            out 1   run finished, held until next start or reset
//   pass_count      out 16  matching results
//   fail_count      out 16  mismatching results
//   first_fail_idx  out 16  op index of first mismatch, 16'hFFFF if none
module alu_op_driver
    import types_pkg::*;
#(
    parameter int unsigned NUM_OPS = 16,
    parameter int unsigned LATENCY = 1,
    parameter logic [15:0] SEED    = 16'hACE1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic [15:0] value1,
    output logic [15:0] value2,
    output op_type      mode,
    input  logic [31:0] result,
    output logic        busy,
    output logic        done,
    output logic [15:0] pass_count,
    output logic [15:0] fail_count,
    output logic [15:0] first_fail_idx
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [15:0] SEED_EFF = (SEED == 16'd0) ? 16'h0001 : SEED;
    localparam logic [15:0] LAST_IDX = 16'(NUM_OPS - 1);
    localparam logic [3:0]  LAT_MAX  = 4'(LATENCY);

    state_t      state_q, state_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [15:0] value1_q, value1_d;
    logic [15:0] value2_q, value2_d;
    op_type      mode_q, mode_d;
    logic [15:0] idx_q, idx_d;
    logic [3:0]  wait_q, wait_d;
    logic [15:0] pass_q, pass_d;
    logic [15:0] fail_q, fail_d;
    logic [15:0] ffi_q, ffi_d;

    logic [31:0] expected;
    logic        mismatch;
    logic        stop_now;
    logic        last_op;
    logic [15:0] lfsr_base;
    logic [15:0] step1;
    logic [15:0] step2;
    logic [15:0] idx_next;

    alu_ref_model u_ref (
        .v1       (value1_q),
        .v2       (value2_q),
        .mode     (mode_q),
        .expected (expected)
    );

    assign mismatch = (result != expected);
    assign last_op  = (idx_q == LAST_IDX);
    assign idx_next = idx_q + 16'd1;

`ifdef ALU_DRV_STOP_ON_FAIL_EN
    assign stop_now = mismatch;
`else
    assign stop_now = 1'b0;
`endif

    // A run always begins from the seed; within a run the sequence continues
    // from the last state, so each op consumes exactly two LFSR steps.
    assign lfsr_base = (state_q == S_RUN) ? lfsr_q : SEED_EFF;
    assign step1     = lfsr_step(lfsr_base);
    assign step2     = lfsr_step(step1);

    always_comb begin
        state_d  = state_q;
        lfsr_d   = lfsr_q;
        value1_d = value1_q;
        value2_d = value2_q;
        mode_d   = mode_q;
        idx_d    = idx_q;
        wait_d   = wait_q;
        pass_d   = pass_q;
        fail_d   = fail_q;
        ffi_d    = ffi_q;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d  = S_RUN;
                    lfsr_d   = step2;
                    value1_d = step1;
                    value2_d = step2;
                    mode_d   = ADD;
                    idx_d    = 16'd0;
                    wait_d   = 4'd0;
                    pass_d   = 16'd0;
                    fail_d   = 16'd0;
                    ffi_d    = NO_FAIL_IDX;
                end
            end
            S_RUN: begin
                if (wait_q != LAT_MAX) begin
                    wait_d = wait_q + 4'd1;
                end else begin
                    // Compare cycle: result belongs to the operands held now.
                    if (mismatch) begin
                        fail_d = fail_q + 16'd1;
                        if (fail_q == 16'd0) begin
                            ffi_d = idx_q;
                        end
                    end else begin
                        pass_d = pass_q + 16'd1;
                    end

                    if (last_op || stop_now) begin
                        // Operands are left untouched so they hold in DONE.
                        state_d = S_DONE;
                    end else begin
                        lfsr_d   = step2;
                        value1_d = step1;
                        value2_d = step2;
                        idx_d    = idx_next;
                        mode_d   = op_type'(idx_next[1:0]);
                        wait_d   = 4'd0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            lfsr_q   <= SEED_EFF;
            value1_q <= 16'd0;
            value2_q <= 16'd0;
            mode_q   <= ADD;
            idx_q    <= 16'd0;
            wait_q   <= 4'd0;
            pass_q   <= 16'd0;
            fail_q   <= 16'd0;
            ffi_q    <= NO_FAIL_IDX;
        end else begin
            state_q  <= state_d;
            lfsr_q   <= lfsr_d;
            value1_q <= value1_d;
            value2_q <= value2_d;
            mode_q   <= mode_d;
            idx_q    <= idx_d;
            wait_q   <= wait_d;
            pass_q   <= pass_d;
            fail_q   <= fail_d;
            ffi_q    <= ffi_d;
        end
    end

    assign value1         = value1_q;
    assign value2         = value2_q;
    assign mode           = mode_q;
    assign busy           = (state_q == S_RUN);
    assign done           = (state_q == S_DONE);
    assign pass_count     = pass_q;
    assign fail_count     = fail_q;
    assign first_fail_idx = ffi_q;

endmodule

// File: tb/tb_alu_op_driver.sv
// tb/tb_alu_op_driver.sv - scoreboard bench for alu_op_driver and alu_ref_model
`timescale 1ns/1ps
module tb_alu_op_driver;
    import types_pkg::*;

    localparam int LAT0 = 1;
    localparam int N0   = 8;
    localparam int LAT1 = 0;
    localparam int N1   = 4;
`ifdef ALU_DRV_STOP_ON_FAIL_EN
    localparam bit STOP_EN = 1'b1;
`else
    localparam bit STOP_EN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start  [2];
    logic [15:0] value1 [2];
    logic [15:0] value2 [2];
    op_type      mode   [2];
    logic [31:0] result [2];
    logic        busy   [2];
    logic        done   [2];
    logic [15:0] pass_c [2];
    logic [15:0] fail_c [2];
    logic [15:0] ffi    [2];
    bit          fault  [2];

    int n_pass  = 0;
    int n_total = 0;

    always #5 clock = ~clock;

    alu_op_driver #(.NUM_OPS(N0), .LATENCY(LAT0), .SEED(16'hACE1)) dut0 (
        .clock(clock), .reset(reset), .start(start[0]),
        .value1(value1[0]), .value2(value2[0]), .mode(mode[0]), .result(result[0]),
        .busy(busy[0]), .done(done[0]), .pass_count(pass_c[0]),
        .fail_count(fail_c[0]), .first_fail_idx(ffi[0])
    );

    alu_op_driver #(.NUM_OPS(N1), .LATENCY(LAT1), .SEED(16'hACE1)) dut1 (
        .clock(clock), .reset(reset), .start(start[1]),
        .value1(value1[1]), .value2(value2[1]), .mode(mode[1]), .result(result[1]),
        .busy(busy[1]), .done(done[1]), .pass_count(pass_c[1]),
        .fail_count(fail_c[1]), .first_fail_idx(ffi[1])
    );

    logic [15:0] rm_a, rm_b;
    op_type      rm_m;
    logic [31:0] rm_y;

    alu_ref_model u_rm (.v1(rm_a), .v2(rm_b), .mode(rm_m), .expected(rm_y));

    // Behavioural ALU on the far side of the port; optional fault flips bit 0 of MUL.
    function automatic logic [31:0] alu_beh(input logic [15:0] a, input logic [15:0] b,
                                            input op_type m, input bit flt);
        int unsigned x;
        int unsigned y;
        logic [31:0] r;
        x = a;
        y = b;
        case (m)
            ADD:     r = x + y;
            SUB:     r = x - y;
            MUL:     r = x * y;
            default: r = (y == 0) ? 32'hFFFF_FFFF : x / y;
        endcase
        if (flt && m == MUL) r = r ^ 32'd1;
        return r;
    endfunction

    always @(posedge clock) result[0] <= alu_beh(value1[0], value2[0], mode[0], fault[0]);
    always_comb result[1] = alu_beh(value1[1], value2[1], mode[1], fault[1]);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    typedef struct { logic [15:0] a; logic [15:0] b; op_type m; } op_exp_t;
    typedef struct { int pass; int fail; logic [15:0] ffi; int cycles; } sum_exp_t;

    op_exp_t  exp_ops[$];
    sum_exp_t exp_sum[$];

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        int unsigned v;
        int unsigned fb;
        v  = s;
        fb = ((v >> 15) ^ (v >> 13) ^ (v >> 12) ^ (v >> 10)) & 1;
        return 16'(((v << 1) | fb) & 32'hFFFF);
    endfunction

    task automatic model_run(input int k, input bit flt);
        int          n;
        int          lat;
        logic [15:0] s;
        op_exp_t     o;
        sum_exp_t    e;
        n   = (k == 0) ? N0 : N1;
        lat = (k == 0) ? LAT0 : LAT1;
        s   = 16'hACE1;
        e.pass = 0; e.fail = 0; e.ffi = 16'hFFFF; e.cycles = 0;
        for (int i = 0; i < n; i++) begin
            s = lfsr_next(s); o.a = s;
            s = lfsr_next(s); o.b = s;
            o.m = op_type'(2'(i % 4));
            exp_ops.push_back(o);
            e.cycles += lat + 1;
            if (flt && (i % 4) == 2) begin
                if (e.fail == 0) e.ffi = 16'(i);
                e.fail++;
                if (STOP_EN) break;
            end else begin
                e.pass++;
            end
        end
        exp_sum.push_back(e);
    endtask

    // ---------------- monitor ----------------
    int   cyc    [2] = '{0, 0};
    logic busy_p [2] = '{1'b0, 1'b0};
    logic done_p [2] = '{1'b0, 1'b0};

    always @(negedge clock) begin : monitor
        int       lat;
        op_exp_t  o;
        sum_exp_t e;
        for (int k = 0; k < 2; k++) begin
            lat = (k == 0) ? LAT0 : LAT1;
            if (busy[k]) begin
                if (!busy_p[k]) cyc[k] = 0;
                if (cyc[k] % (lat + 1) == 0) begin
                    if (exp_ops.size() == 0) begin
                        check("op_queue_empty", 32'd1, 32'd0);
                    end else begin
                        o = exp_ops.pop_front();
                        check("value1", value1[k], o.a);
                        check("value2", value2[k], o.b);
                        check("mode", mode[k], o.m);
                    end
                end
                cyc[k]++;
            end
            if (done[k] && !done_p[k]) begin
                if (exp_sum.size() == 0) begin
                    check("sum_queue_empty", 32'd1, 32'd0);
                end else begin
                    e = exp_sum.pop_front();
                    check("pass_count", pass_c[k], e.pass);
                    check("fail_count", fail_c[k], e.fail);
                    check("first_fail_idx", ffi[k], e.ffi);
                    check("run_cycles", cyc[k], e.cycles);
                    check("busy_at_done", busy[k], 1'b0);
                end
            end
            busy_p[k] = busy[k];
            done_p[k] = done[k];
        end
    end

    // ---------------- stimulus ----------------
    task automatic check_reset(input int k);
        check("rst_busy", busy[k], 1'b0);
        check("rst_done", done[k], 1'b0);
        check("rst_value1", value1[k], 16'd0);
        check("rst_value2", value2[k], 16'd0);
        check("rst_mode", mode[k], ADD);
        check("rst_pass", pass_c[k], 16'd0);
        check("rst_fail", fail_c[k], 16'd0);
        check("rst_ffi", ffi[k], 16'hFFFF);
    endtask

    task automatic do_run(input int k, input bit flt, input bit pulses);
        int guard;
        fault[k] = flt;
        model_run(k, flt);
        start[k] = 1'b1;
        @(posedge clock); #1 start[k] = 1'b0;
        check("busy_after_start", busy[k], 1'b1);
        check("first_value1", value1[k], 16'h59C3);
        check("first_value2", value2[k], 16'hB387);
        guard = 0;
        while (!done[k] && guard < 2000) begin
            if (pulses && busy[k] && $urandom_range(0, 2) == 0) start[k] = 1'b1;
            @(posedge clock); #1 start[k] = 1'b0;
            guard++;
        end
        if (!done[k]) check("done_timeout", 32'd0, 32'd1);
        @(posedge clock); #1;
    endtask

    initial begin : watchdog
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        start[0] = 1'b0; start[1] = 1'b0;
        fault[0] = 1'b0; fault[1] = 1'b0;
        rm_a = 16'd0; rm_b = 16'd0; rm_m = ADD;
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        check_reset(0);
        check_reset(1);

        rm_a = 16'd7;    rm_b = 16'd0;    rm_m = DIV; #1 check("ref_div0", rm_y, 32'hFFFF_FFFF);
        rm_a = 16'd3;    rm_b = 16'd5;    rm_m = SUB; #1 check("ref_sub", rm_y, 32'hFFFF_FFFE);
        rm_a = 16'hFFFF; rm_b = 16'hFFFF; rm_m = MUL; #1 check("ref_mul", rm_y, 32'hFFFE_0001);
        rm_a = 16'hFFFF; rm_b = 16'd1;    rm_m = ADD; #1 check("ref_add", rm_y, 32'h0001_0000);
        rm_a = 16'd100;  rm_b = 16'd7;    rm_m = DIV; #1 check("ref_div", rm_y, 32'd14);

        @(posedge clock); #1;
        do_run(0, 1'b0, 1'b0);
        check("golden_done_held", done[0], 1'b1);
        do_run(0, 1'b1, 1'b0);
        do_run(0, 1'b0, 1'b1);
        do_run(1, 1'b0, 1'b0);
        do_run(1, 1'b1, 1'b0);

        // Reset in the middle of op 3, then a clean rerun must repeat the sequence.
        fault[0] = 1'b0;
        model_run(0, 1'b0);
        start[0] = 1'b1;
        @(posedge clock); #1 start[0] = 1'b0;
        repeat (3 * (LAT0 + 1)) @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock); #1 reset = 1'b0;
        exp_ops.delete();
        exp_sum.delete();
        check_reset(0);
        @(posedge clock); #1;
        do_run(0, 1'b0, 1'b0);

        for (int r = 0; r < 6; r++) begin
            do_run(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
        end

        check("leftover_ops", exp_ops.size(), 32'd0);
        check("leftover_sums", exp_sum.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
